// File: rtl/debounce_edge_fsm.sv
// Debouncer with a two-flop synchronizer, a four-state settle FSM and registered edge pulses.
// Optional long-press pulse is enabled by defining DEBOUNCE_LONGPRESS_EN.
module debounce_edge_fsm #(
    parameter int T_DEB  = 5,
    parameter int T_LONG = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_press,
    output logic bouncing
);

    typedef enum logic [1:0] {
        S_LOW,
        S_WAIT_HIGH,
        S_HIGH,
        S_WAIT_LOW
    } state_t;

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int T_MAX = (T_LONG > T_DEB) ? T_LONG : T_DEB;
`else
    localparam int T_MAX = T_DEB;
`endif
    localparam int TW = $clog2(T_MAX + 1);
    localparam logic [TW-1:0] T_DEB_LAST = TW'(T_DEB - 1);
    localparam logic [TW-1:0] T_SAT      = '1;

    if (T_DEB < 1 || T_DEB > 65535 || T_LONG < 1 || T_LONG > 65535) begin : g_bad_param
        $error("debounce_edge_fsm: T_DEB and T_LONG must be in 1..65535");
    end

    state_t          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic            sync1_q, sync1_d;
    logic            btn_s_q, btn_s_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            long_press_q, long_press_d;
    logic            bouncing_q, bouncing_d;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        sync1_d      = btn_raw;
        btn_s_d      = sync1_q;
        state_d      = state_q;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        long_press_d = 1'b0;

        // Reversal is tested before timer expiry, so a bounce on the last count wins.
        case (state_q)
            S_LOW: begin
                if (btn_s_q) state_d = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (!btn_s_q) begin
                    state_d = S_LOW;
                end else if (t_q == T_DEB_LAST) begin
                    state_d = S_HIGH;
                    rise_d  = 1'b1;
                end
            end
            S_HIGH: begin
                if (!btn_s_q) state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (btn_s_q) begin
                    state_d = S_HIGH;
                end else if (t_q == T_DEB_LAST) begin
                    state_d = S_LOW;
                    fall_d  = 1'b1;
                end
            end
            default: state_d = S_LOW;
        endcase

`ifdef DEBOUNCE_LONGPRESS_EN
        long_press_d = (state_q == S_HIGH) && (t_q == TW'(T_LONG - 1));
`endif

        // Saturation keeps t parked above T_LONG-1, so long_press fires once per press.
        if (state_d != state_q)  t_d = '0;
        else if (t_q != T_SAT)   t_d = t_q + 1'b1;
        else                     t_d = t_q;

        level_d    = (state_d == S_HIGH)      || (state_d == S_WAIT_LOW);
        bouncing_d = (state_d == S_WAIT_HIGH) || (state_d == S_WAIT_LOW);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_LOW;
            t_q          <= '0;
            sync1_q      <= 1'b0;
            btn_s_q      <= 1'b0;
            level_q      <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            long_press_q <= 1'b0;
            bouncing_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            sync1_q      <= sync1_d;
            btn_s_q      <= btn_s_d;
            level_q      <= level_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            long_press_q <= long_press_d;
            bouncing_q   <= bouncing_d;
        end
    end

    assign level      = level_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign long_press = long_press_q;
    assign bouncing   = bouncing_q;

endmodule

// File: tb/tb_debounce_edge_fsm.sv
// Directed bench for debounce_edge_fsm (T_DEB=5, T_LONG=50); edge numbers count from the
// first rising edge that samples a new btn_raw value.
module tb_debounce_edge_fsm;

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic btn_raw;
    logic level, rise, fall, long_press, bouncing;

    int n_checks = 0;
    int n_fail   = 0;

    debounce_edge_fsm #(.T_DEB(5), .T_LONG(50)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .long_press (long_press),
        .bouncing   (bouncing)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int e, input logic e_level, input logic e_rise,
                             input logic e_fall, input logic e_lp, input logic e_bnc);
        check($sformatf("%s e%0d level", tag, e),      level,      e_level);
        check($sformatf("%s e%0d rise", tag, e),       rise,       e_rise);
        check($sformatf("%s e%0d fall", tag, e),       fall,       e_fall);
        check($sformatf("%s e%0d long_press", tag, e), long_press, e_lp);
        check($sformatf("%s e%0d bouncing", tag, e),   bouncing,   e_bnc);
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        btn_raw = 1'b1;

        // Reset held for 3 edges with the button pressed: everything stays 0.
        for (int e = 1; e <= 3; e++) begin
            tick();
            check_all("reset", e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        reset = 1'b1;

        // Press after release: rise at edge 8, then held; long press 50 edges after rise.
        for (int e = 1; e <= 108; e++) begin
            tick();
            check_all("press", e, e >= 8, e == 8, 1'b0, LP_EN && (e == 58), (e >= 3) && (e <= 7));
        end

        // Clean release held low for 10 cycles: single fall at edge 8.
        btn_raw = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_all("release", e, e < 8, 1'b0, e == 8, 1'b0, (e >= 3) && (e <= 7));
        end

        // 3-cycle glitch: bouncing pulses, no level change, no edge pulses.
        for (int e = 1; e <= 12; e++) begin
            btn_raw = (e <= 3);
            tick();
            check_all("glitch", e, 1'b0, 1'b0, 1'b0, 1'b0, (e >= 3) && (e <= 5));
        end

        // btn_s drops exactly when t reaches T_DEB-1: back to S_LOW with no rise.
        for (int e = 1; e <= 14; e++) begin
            btn_raw = (e <= 5);
            tick();
            check_all("lastcnt", e, 1'b0, 1'b0, 1'b0, 1'b0, (e >= 3) && (e <= 7));
        end

        // Reach S_HIGH, then reset mid-press: level drops, no fall.
        btn_raw = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_all("press2", e, e >= 8, e == 8, 1'b0, 1'b0, (e >= 3) && (e <= 7));
        end
        reset = 1'b0;
        for (int e = 1; e <= 2; e++) begin
            tick();
            check_all("midreset", e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        reset = 1'b1;

        // Button still held after release: a fresh rise after the full latency.
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_all("repress", e, e >= 8, e == 8, 1'b0, 1'b0, (e >= 3) && (e <= 7));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
